// File: rtl/cmd_dispatcher.sv
// cmd_dispatcher: in-order command FIFO that forwards host command words to
// one of NUM_CORES NTT engine cores over a shared (broadcast) command bus.
//
// Ports
//   clk, rst        clock; synchronous active-high reset
//   host_valid/cmd  host command word {opcode, slot, core id, 48b DMA address}
//   host_ready      FIFO not full
//   core_ready      per-core engine ready
//   cmd_valid       per-core one-cycle strobe (one-hot or zero)
//   cmd_opcode/slot/dma_addr  broadcast bus, updated only on a strobe
//   idle            nothing queued, all cores ready, no strobe in flight
//   err_bad_core    sticky: a command named a non-existent core
//   dispatch_count  commands forwarded since reset (wrapping)
module cmd_dispatcher #(
  parameter int         NUM_CORES  = 2,
  parameter int         FIFO_DEPTH = 8,
  parameter logic [7:0] OP_FENCE   = 8'hFF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 host_valid,
  input  logic [63:0]          host_cmd,
  output logic                 host_ready,
  input  logic [NUM_CORES-1:0] core_ready,
  output logic [NUM_CORES-1:0] cmd_valid,
  output logic [7:0]           cmd_opcode,
  output logic [3:0]           cmd_slot,
  output logic [47:0]          cmd_dma_addr,
  output logic                 idle,
  output logic                 err_bad_core,
  output logic [31:0]          dispatch_count
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(FIFO_DEPTH);

  logic [63:0]          r_mem [FIFO_DEPTH];
  logic [AW-1:0]        r_wptr, r_rptr;
  logic [AW:0]          r_count;
  logic [NUM_CORES-1:0] r_cmd_valid;
  logic [7:0]           r_opcode;
  logic [3:0]           r_slot;
  logic [47:0]          r_addr;
  logic [31:0]          r_disp_cnt;
  logic                 r_err;

  logic                 w_empty, w_push, w_pop, w_disp;
  logic                 w_fence, w_bad, w_quiet, w_hit;
  logic [63:0]          w_head;
  logic [3:0]           w_cid;
  logic [NUM_CORES-1:0] w_sel, w_avail;

  assign w_empty    = (r_count == '0);
  assign host_ready = (r_count != FULL_CNT);
  assign w_push     = host_valid & host_ready;

  assign w_head  = r_mem[r_rptr];
  assign w_cid   = w_head[51:48];
  assign w_fence = (w_head[63:56] == OP_FENCE);
  assign w_bad   = ({28'd0, w_cid} >= 32'(NUM_CORES));

  // A core that was strobed last cycle may drop ready only now, so it is
  // masked out for that cycle to avoid issuing it a second command.
  assign w_avail = core_ready & ~r_cmd_valid;
  assign w_quiet = (&core_ready) && (r_cmd_valid == '0);

  always_comb begin
    w_sel = '0;
    for (int k = 0; k < NUM_CORES; k++)
      w_sel[k] = ({28'd0, w_cid} == 32'(k));
  end

  assign w_hit  = |(w_sel & w_avail);
  assign w_disp = !w_empty && !w_fence && !w_bad && w_hit;
  // Fence drains on quiet cores; bad-core entries are dropped immediately.
  assign w_pop  = !w_empty && (w_fence ? w_quiet : (w_bad || w_hit));

  always_ff @(posedge clk)
    if (w_push) r_mem[r_wptr] <= host_cmd;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wptr      <= '0;
      r_rptr      <= '0;
      r_count     <= '0;
      r_cmd_valid <= '0;
      r_opcode    <= '0;
      r_slot      <= '0;
      r_addr      <= '0;
      r_disp_cnt  <= '0;
      r_err       <= 1'b0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: ;
      endcase
      r_cmd_valid <= w_disp ? w_sel : '0;
      if (w_disp) begin
        r_opcode   <= w_head[63:56];
        r_slot     <= w_head[55:52];
        r_addr     <= w_head[47:0];
        r_disp_cnt <= r_disp_cnt + 32'd1;
      end
      if (!w_empty && !w_fence && w_bad) r_err <= 1'b1;
    end
  end

  assign cmd_valid      = r_cmd_valid;
  assign cmd_opcode     = r_opcode;
  assign cmd_slot       = r_slot;
  assign cmd_dma_addr   = r_addr;
  assign dispatch_count = r_disp_cnt;
  assign err_bad_core   = r_err;
  assign idle           = w_empty && (&core_ready) && (r_cmd_valid == '0);
endmodule

// File: tb/tb_cmd_dispatcher.sv
module tb_cmd_dispatcher;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        host_valid = 1'b0;
  logic [63:0] host_cmd = '0;
  logic        host_ready;
  logic [1:0]  core_ready = 2'b00;
  logic [1:0]  cmd_valid;
  logic [7:0]  cmd_opcode;
  logic [3:0]  cmd_slot;
  logic [47:0] cmd_dma_addr;
  logic        idle, err_bad_core;
  logic [31:0] dispatch_count;

  cmd_dispatcher #(.NUM_CORES(2), .FIFO_DEPTH(8), .OP_FENCE(8'hFF)) dut (
    .clk(clk), .rst(rst), .host_valid(host_valid), .host_cmd(host_cmd),
    .host_ready(host_ready), .core_ready(core_ready), .cmd_valid(cmd_valid),
    .cmd_opcode(cmd_opcode), .cmd_slot(cmd_slot), .cmd_dma_addr(cmd_dma_addr),
    .idle(idle), .err_bad_core(err_bad_core), .dispatch_count(dispatch_count));

  always #5 clk = ~clk;

  typedef struct {
    int          core;
    logic [7:0]  op;
    logic [3:0]  slot;
    logic [47:0] addr;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad = 0;
  int   exp_cnt = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", nm, act, req, $time);
    end
  endtask

  function automatic logic [63:0] mk(input logic [7:0] op, input logic [3:0] slot,
                                     input logic [3:0] cid, input logic [47:0] addr);
    return {op, slot, cid, addr};
  endfunction

  // Drive one word for one cycle; queue the expected strobe if it is accepted
  // and is a normal command to a real core.
  task automatic push(input logic [63:0] w, input bit disp, output bit acc);
    exp_t e;
    host_valid = 1'b1;
    host_cmd   = w;
    acc        = host_ready;
    if (acc && disp) begin
      e.core = int'(w[51:48]); e.op = w[63:56]; e.slot = w[55:52]; e.addr = w[47:0];
      exp_q.push_back(e);
    end
    @(posedge clk); #1;
    host_valid = 1'b0;
  endtask

  task automatic wait_drain(input string nm);
    int n = 0;
    while (!(idle && exp_q.size() == 0) && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    chk(nm, {63'd0, idle && exp_q.size() == 0}, 64'd1);
  endtask

  // Monitor: every strobe must match the head of the expected queue.
  always @(negedge clk) begin
    exp_t e;
    if (!rst && cmd_valid != 2'b00) begin
      chk("onehot", 64'($countones(cmd_valid)), 64'd1);
      if (exp_q.size() == 0) begin
        chk("unexpected_strobe", {62'd0, cmd_valid}, 64'd0);
      end else begin
        e = exp_q.pop_front();
        exp_cnt++;
        chk("strobe_core", {62'd0, cmd_valid}, 64'd1 << e.core);
        chk("opcode", {56'd0, cmd_opcode}, {56'd0, e.op});
        chk("slot", {60'd0, cmd_slot}, {60'd0, e.slot});
        chk("addr", {16'd0, cmd_dma_addr}, {16'd0, e.addr});
        chk("dispatch_count", {32'd0, dispatch_count}, 64'(exp_cnt));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit acc;
    logic [31:0] cnt0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_cmd_valid", {62'd0, cmd_valid}, 64'd0);
    chk("rst_opcode", {56'd0, cmd_opcode}, 64'd0);
    chk("rst_slot", {60'd0, cmd_slot}, 64'd0);
    chk("rst_addr", {16'd0, cmd_dma_addr}, 64'd0);
    chk("rst_count", {32'd0, dispatch_count}, 64'd0);
    chk("rst_err", {63'd0, err_bad_core}, 64'd0);
    chk("rst_host_ready", {63'd0, host_ready}, 64'd1);
    chk("idle_cores_busy", {63'd0, idle}, 64'd0);
    rst = 1'b0;
    core_ready = 2'b11;
    #1 chk("idle_after_rst", {63'd0, idle}, 64'd1);

    // Single dispatch and latency
    push(mk(8'h02, 4'h3, 4'h1, 48'h1000), 1'b1, acc);
    chk("lat_E", {62'd0, cmd_valid}, 64'd0);
    @(posedge clk); #1;
    chk("lat_E1_strobe", {62'd0, cmd_valid}, 64'd2);
    chk("single_opcode", {56'd0, cmd_opcode}, 64'h02);
    chk("single_addr", {16'd0, cmd_dma_addr}, 64'h1000);
    chk("single_count", {32'd0, dispatch_count}, 64'd1);
    @(posedge clk); #1;
    chk("one_cycle", {62'd0, cmd_valid}, 64'd0);
    chk("bus_hold_op", {56'd0, cmd_opcode}, 64'h02);
    chk("bus_hold_slot", {60'd0, cmd_slot}, 64'h3);

    // Head-of-line blocking, then back-to-back
    core_ready = 2'b10;
    push(mk(8'h11, 4'h1, 4'h0, 48'h2000), 1'b1, acc);
    push(mk(8'h12, 4'h2, 4'h1, 48'h2100), 1'b1, acc);
    repeat (3) @(posedge clk);
    #1;
    chk("hol_no_strobe", {62'd0, cmd_valid}, 64'd0);
    chk("hol_pending", 64'(exp_q.size()), 64'd2);
    core_ready = 2'b11;
    @(posedge clk); #1;
    chk("hol_core0", {62'd0, cmd_valid}, 64'd1);
    @(posedge clk); #1;
    chk("b2b_core1", {62'd0, cmd_valid}, 64'd2);
    wait_drain("hol_drain");

    // Full FIFO with pointer wrap
    core_ready = 2'b00;
    for (int i = 0; i < 9; i++) begin
      push(mk(8'h20 + 8'(i), 4'(i), 4'(i % 2), 48'(i * 256)), 1'b1, acc);
      chk("full_accept", {63'd0, acc}, (i < 8) ? 64'd1 : 64'd0);
      if (i == 7) chk("full_ready_low", {63'd0, host_ready}, 64'd0);
    end
    core_ready = 2'b11;
    @(posedge clk); #1;
    chk("full_ready_rise", {63'd0, host_ready}, 64'd1);
    wait_drain("full_drain");
    chk("full_count", {32'd0, dispatch_count}, 64'd11);

    // Fence
    core_ready = 2'b10;
    cnt0 = dispatch_count;
    push(mk(8'h30, 4'h0, 4'h1, 48'h3000), 1'b1, acc);
    push(mk(8'hFF, 4'h0, 4'h0, 48'h0), 1'b0, acc);
    push(mk(8'h31, 4'h1, 4'h1, 48'h3100), 1'b1, acc);
    repeat (4) @(posedge clk);
    #1;
    chk("fence_first_only", {32'd0, dispatch_count}, {32'd0, cnt0 + 32'd1});
    chk("fence_held", 64'(exp_q.size()), 64'd1);
    core_ready = 2'b11;
    wait_drain("fence_drain");
    chk("fence_count", {32'd0, dispatch_count}, {32'd0, cnt0 + 32'd2});

    // Bad core id
    cnt0 = dispatch_count;
    push(mk(8'h05, 4'h0, 4'h5, 48'h5000), 1'b0, acc);
    repeat (3) @(posedge clk);
    #1;
    chk("bad_err", {63'd0, err_bad_core}, 64'd1);
    chk("bad_count", {32'd0, dispatch_count}, {32'd0, cnt0});
    chk("bad_popped_idle", {63'd0, idle}, 64'd1);
    push(mk(8'h40, 4'h4, 4'h0, 48'h4000), 1'b1, acc);
    wait_drain("bad_drain");
    chk("bad_sticky", {63'd0, err_bad_core}, 64'd1);

    // Reset mid-stream with queued entries
    core_ready = 2'b00;
    for (int i = 0; i < 3; i++)
      push(mk(8'h50 + 8'(i), 4'h0, 4'(i % 2), 48'h6000), 1'b1, acc);
    rst = 1'b1;
    @(posedge clk); #1;
    exp_q.delete();
    exp_cnt = 0;
    rst = 1'b0;
    chk("rst_mid_valid", {62'd0, cmd_valid}, 64'd0);
    chk("rst_mid_count", {32'd0, dispatch_count}, 64'd0);
    chk("rst_mid_err", {63'd0, err_bad_core}, 64'd0);
    chk("rst_mid_ready", {63'd0, host_ready}, 64'd1);
    core_ready = 2'b11;
    repeat (5) @(posedge clk);
    #1;
    chk("rst_mid_idle", {63'd0, idle}, 64'd1);
    chk("rst_mid_none", {32'd0, dispatch_count}, 64'd0);

    // Reset on the edge that would pop a pending command
    push(mk(8'h60, 4'h0, 4'h0, 48'h7000), 1'b1, acc);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("rst_suppress", {62'd0, cmd_valid}, 64'd0);
    exp_q.delete();
    exp_cnt = 0;
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_suppress_none", {32'd0, dispatch_count}, 64'd0);
    chk("queue_empty", 64'(exp_q.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
